// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared definitions for the instruction memory controller
//
// Purpose: instruction word layout and controller FSM state encoding, shared by
// the controller and anything that wires it to the instruction memory.
// Ports: none (package).

package imem_ctrl_pkg;

  localparam int unsigned instr_width_lp = 32;

  // One instruction word as stored in memory and returned to the core.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_s;

  // Controller modes: waiting for a first load, loading from host, serving fetches.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory controller: host program load and core fetch path
//
// Purpose: owns the port of an external synchronous instruction memory. In LOAD
// it writes host words at consecutive addresses from 0; in RUN it serves core
// fetches with one cycle of latency and full throughput.
// Ports:
//   clk, reset_n_i                        clock, asynchronous active-low reset
//   load_start_i                          pulse: start a program load
//   host_valid_i/host_instr_i/host_last_i host load stream, host_ready_o accepts
//   fetch_valid_i/fetch_addr_i            core fetch request, fetch_ready_o accepts
//   resp_valid_o/resp_instr_o             fetch response, consumed by resp_ready_i
//   mem_addr_o/mem_instr_o/mem_wen_o      to instruction memory
//   mem_instr_i                           read data from instruction memory (1 cycle)
//   loaded_o                              a load has completed since the last load_start_i

module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    load_start_i,
  input  logic                    host_valid_i,
  input  instruction_s            host_instr_i,
  input  logic                    host_last_i,
  output logic                    host_ready_o,
  input  logic                    fetch_valid_i,
  input  logic [addr_width_p-1:0] fetch_addr_i,
  output logic                    fetch_ready_o,
  output logic                    resp_valid_o,
  output instruction_s            resp_instr_o,
  input  logic                    resp_ready_i,
  output logic [addr_width_p-1:0] mem_addr_o,
  output instruction_s            mem_instr_o,
  output logic                    mem_wen_o,
  input  instruction_s            mem_instr_i,
  output logic                    loaded_o
);

  localparam logic [addr_width_p-1:0] cnt_max_lp = '1;

  imem_state_e             state_q, state_d;
  logic [addr_width_p-1:0] cnt_q, cnt_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    loaded_q, loaded_d;
  logic                    load_pend_q, load_pend_d;

  logic load_req;
  logic can_drain;
  logic host_acc;
  logic fetch_acc;

  always_comb begin
    // A load requested while a response is stuck is remembered until it drains.
    load_req      = load_start_i | load_pend_q;
    can_drain     = !resp_valid_q | resp_ready_i;

    host_ready_o  = (state_q == LOAD);
    // No new fetch is taken once a load is requested: its response would be lost.
    fetch_ready_o = (state_q == RUN) & can_drain & !load_req;
    host_acc      = host_ready_o & host_valid_i;
    fetch_acc     = fetch_ready_o & fetch_valid_i;

    mem_wen_o     = host_acc;
    mem_instr_o   = host_instr_i;
    resp_instr_o  = mem_instr_i;

    // Re-presenting addr_q while stalled makes the memory re-read the same word,
    // which keeps resp_instr_o stable without a holding register.
    if (state_q == LOAD) begin
      mem_addr_o = cnt_q;
    end else if (fetch_acc) begin
      mem_addr_o = fetch_addr_i;
    end else begin
      mem_addr_o = addr_q;
    end

    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    loaded_d     = loaded_q;
    load_pend_d  = load_pend_q;

    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        resp_valid_d = 1'b0;
        if (host_acc) begin
          // Writing the top address ends the load even without host_last_i.
          if (host_last_i || (cnt_q == cnt_max_lp)) begin
            state_d  = RUN;
            cnt_d    = '0;
            loaded_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RUN: begin
        if (load_req) begin
          if (can_drain) begin
            state_d      = LOAD;
            cnt_d        = '0;
            resp_valid_d = 1'b0;
            loaded_d     = 1'b0;
            load_pend_d  = 1'b0;
          end else begin
            load_pend_d = 1'b1;
          end
        end else if (fetch_acc) begin
          addr_d       = fetch_addr_i;
          resp_valid_d = 1'b1;
        end else if (resp_ready_i) begin
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      loaded_q     <= 1'b0;
      load_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      loaded_q     <= loaded_d;
      load_pend_q  <= load_pend_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign loaded_o     = loaded_q;

endmodule
